// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit and the decoder that drives it.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_DUM = 4'd0,
    MULT    = 4'd1,
    MULTU   = 4'd2,
    DIV     = 4'd3,
    DIVU    = 4'd4,
    MADD    = 4'd5,
    MADDU   = 4'd6,
    MSUB    = 4'd7,
    MSUBU   = 4'd8
  } mdu_op_e;

  localparam logic [1:0] MT_NONE = 2'b00;
  localparam logic [1:0] MT_LO   = 2'b01;
  localparam logic [1:0] MT_HI   = 2'b11;

  localparam logic [1:0] MF_NONE = 2'b00;
  localparam logic [1:0] MF_LO   = 2'b01;
  localparam logic [1:0] MF_HI   = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  // Wide enough to hold a latency of 64.
  localparam int CNT_W = 7;

  function automatic logic is_mdu_op(input logic [3:0] op);
    return (op >= 4'(MULT)) && (op <= 4'(MSUBU));
  endfunction

endpackage

// File: rtl/mdu_divide.sv
// Combinational signed/unsigned divider: magnitude divide plus sign and MIN/-1 fix-up.
module mdu_divide
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sgn,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             dz
);

  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE_V = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             neg_a, neg_b, ovf;
  logic [WIDTH-1:0] ua, ub, uq, ur;

  always_comb begin
    neg_a = sgn & a[WIDTH-1];
    neg_b = sgn & b[WIDTH-1];
    ua    = neg_a ? -a : a;
    ub    = neg_b ? -b : b;
    dz    = (b == '0);
    // Keep the divider defined on zero; the caller discards the result.
    if (dz) ub = ONE_V;
    uq    = ua / ub;
    ur    = ua % ub;
    quo   = (neg_a ^ neg_b) ? -uq : uq;
    rem   = neg_a ? -ur : ur;
    ovf   = sgn && (a == MIN_V) && (&b);
    if (ovf) begin
      quo = MIN_V;
      rem = '0;
    end
  end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; result is computed at launch and
// committed when the latency counter expires.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mthilo,
  input  logic [WIDTH-1:0] wdata,
  input  logic [1:0]       mfhilo,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rdata
);

  localparam int W2 = 2 * WIDTH;

  mdu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [W2-1:0]    pend;
  logic             keep;

  logic             launch, is_sgn, is_div, is_acc, is_sub;
  logic [W2-1:0]    ax, bx, prod, base, mul_res;
  logic [WIDTH-1:0] quo, rem;
  logic             dz;

  always_comb begin
    is_sgn = 1'b0;
    is_div = 1'b0;
    is_acc = 1'b0;
    is_sub = 1'b0;
    case (op)
      4'(MULT):  is_sgn = 1'b1;
      4'(DIV):   begin is_sgn = 1'b1; is_div = 1'b1; end
      4'(DIVU):  is_div = 1'b1;
      4'(MADD):  begin is_sgn = 1'b1; is_acc = 1'b1; end
      4'(MADDU): is_acc = 1'b1;
      4'(MSUB):  begin is_sgn = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
      4'(MSUBU): begin is_acc = 1'b1; is_sub = 1'b1; end
      default:   ;
    endcase
    launch = start && is_mdu_op(op) && (state == IDLE);
  end

  // Product modulo 2^(2W): extending both operands to 2W bits gives the
  // correct signed or unsigned full product in the low 2W bits.
  always_comb begin
    ax      = is_sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    bx      = is_sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    prod    = ax * bx;
    base    = {hi, lo};
    mul_res = is_acc ? (is_sub ? base - prod : base + prod) : prod;
  end

  mdu_divide #(.WIDTH(WIDTH)) u_div (
    .a   (a),
    .b   (b),
    .sgn (is_sgn),
    .quo (quo),
    .rem (rem),
    .dz  (dz)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      pend  <= '0;
      keep  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            pend  <= is_div ? {rem, quo} : mul_res;
            keep  <= is_div & dz;
          end else if (!start) begin
            // A start in the same cycle takes priority over a move-to.
            if (mthilo == MT_LO) lo <= wdata;
            if (mthilo == MT_HI) hi <= wdata;
          end
        end
        RUN: begin
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            if (!keep) {hi, lo} <= pend;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    case (mfhilo)
      MF_LO:   rdata = lo;
      MF_HI:   rdata = hi;
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Randomized bench for mdu_unit against an arithmetic model of HI/LO.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic [1:0]  mthilo = '0, mfhilo = '0;
  logic        busy;
  logic [31:0] hi, lo, rdata;

  int total = 0;
  int bad = 0;
  logic [63:0] hl = '0;

  mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthilo(mthilo), .wdata(wdata), .mfhilo(mfhilo),
    .busy(busy), .hi(hi), .lo(lo), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_op(input int opc, input logic [31:0] x, input logic [31:0] y,
                                         input logic [63:0] acc);
    logic [63:0] ps, pu;
    int sx, sy, q, r;
    ps = longint'($signed(x)) * longint'($signed(y));
    pu = {32'd0, x} * {32'd0, y};
    sx = x;
    sy = y;
    case (opc)
      1: return ps;
      2: return pu;
      3: begin
        if (y == 0) return acc;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sx / sy;
        r = sx % sy;
        return {r, q};
      end
      4: begin
        if (y == 0) return acc;
        return {x % y, x / y};
      end
      5: return acc + ps;
      6: return acc + pu;
      7: return acc - ps;
      8: return acc - pu;
      default: return acc;
    endcase
  endfunction

  task automatic check_regs(input string tag);
    chk({tag, "_hi"}, {32'd0, hi}, {32'd0, hl[63:32]});
    chk({tag, "_lo"}, {32'd0, lo}, {32'd0, hl[31:0]});
    mfhilo = 2'b01; #1 chk({tag, "_mflo"}, {32'd0, rdata}, {32'd0, hl[31:0]});
    mfhilo = 2'b10; #1 chk({tag, "_mfhi"}, {32'd0, rdata}, {32'd0, hl[63:32]});
    mfhilo = 2'b00; #1 chk({tag, "_mf0"}, {32'd0, rdata}, 64'd0);
  endtask

  task automatic mt(input logic [1:0] code, input logic [31:0] d);
    mthilo = code;
    wdata  = d;
    @(posedge clk); #1;
    mthilo = 2'b00;
    if (code == 2'b01) hl[31:0] = d;
    if (code == 2'b11) hl[63:32] = d;
  endtask

  // poke: during busy try a second start, an MTLO and a move-from.
  // same_mt: assert MTLO together with start; the move must be dropped.
  task automatic run_op(input int opc, input logic [31:0] x, input logic [31:0] y,
                        input bit poke, input bit same_mt);
    int n;
    logic [63:0] nxt;
    n   = (opc == 3 || opc == 4) ? 10 : 5;
    nxt = ref_op(opc, x, y, hl);
    start = 1'b1; op = opc[3:0]; a = x; b = y;
    if (same_mt) begin mthilo = 2'b01; wdata = 32'hDEAD_BEEF; end
    @(posedge clk); #1;
    start = 1'b0; mthilo = 2'b00;
    a = $urandom; b = $urandom; op = 4'($urandom_range(0, 8));
    for (int i = 0; i < n; i++) begin
      chk("busy_hi", {63'd0, busy}, 64'd1);
      if (poke && i == 1) begin
        start = 1'b1; op = 4'd2; a = 32'd7; b = 32'd9;
        mthilo = 2'b01; wdata = 32'h0000_1234; mfhilo = 2'b01;
        #1 chk("rd_busy", {32'd0, rdata}, {32'd0, hl[31:0]});
      end
      @(posedge clk); #1;
      start = 1'b0; mthilo = 2'b00; mfhilo = 2'b00;
    end
    hl = nxt;
    chk("busy_lo", {63'd0, busy}, 64'd0);
    check_regs("res");
  endtask

  initial begin
    logic [31:0] x, y;
    int opc;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    check_regs("rst");

    run_op(1, 32'hFFFF_FFFE, 32'd3, 0, 0);
    mt(2'b11, 32'd0);
    mt(2'b01, 32'd10);
    check_regs("mt");
    run_op(6, 32'hFFFF_FFFF, 32'd2, 0, 0);
    run_op(7, 32'd1, 32'd8, 0, 0);
    run_op(3, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    mt(2'b11, 32'd5);
    mt(2'b01, 32'd6);
    run_op(4, 32'd100, 32'd0, 0, 0);
    run_op(3, 32'd100, 32'd0, 0, 0);
    run_op(1, 32'h1234_5678, 32'h9ABC_DEF0, 1, 0);
    run_op(4, 32'hFFFF_0000, 32'd3, 1, 1);

    // Reset in the third busy cycle of a divide.
    start = 1'b1; op = 4'd3; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    hl = '0;
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    check_regs("rst_mid");
    run_op(1, 32'd11, 32'hFFFF_FFFD, 0, 0);

    for (int k = 0; k < 40; k++) begin
      opc = $urandom_range(1, 8);
      x = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: y = 32'hFFFF_FFFF;
        2: y = 32'($urandom_range(1, 20));
        default: y = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) mt($urandom_range(0, 1) ? 2'b01 : 2'b11, $urandom);
      run_op(opc, x, y, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
